// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, access sizes and alignment helper for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Illegal sizes report as misaligned so one check covers both error classes
  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [2:0] len);
    case (len)
      LEN_B:   return 1'b1;
      LEN_H:   return ~addr_lo[0];
      LEN_W:   return addr_lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian byte-lane steering for stores and loads
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [1:0]  offs,
  input  logic [2:0]  len,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);

  logic [4:0]  sh;
  logic [31:0] rshift;

  assign sh = {offs, 3'b000};

  always_comb begin
    be       = 4'b0000;
    rdata    = 32'h0;
    wdata_sh = wdata << sh;
    rshift   = rword >> sh;
    case (len)
      LEN_B: begin
        be    = 4'b0001 << offs;
        rdata = {24'h0, rshift[7:0]};
      end
      LEN_H: begin
        be    = 4'b0011 << offs;
        rdata = {16'h0, rshift[15:0]};
      end
      LEN_W: begin
        be    = 4'b1111;
        rdata = rshift;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with internal word array
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_len,
  input  logic        req_wen,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic [31:0]   off;
  logic          in_range;
  logic          err;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   ld_data;

  // Gating ready with reset keeps it low while reset is held, even though the FSM sits in IDLE
  assign req_ready = (state == IDLE) && !reset;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  assign off      = req_addr - BASE;
  assign in_range = (req_addr >= BASE) && (off < SPAN);
  assign err      = !in_range || !is_aligned(req_addr[1:0], req_len);
  assign idx      = in_range ? off[AW+1:2] : '0;

  dmem_lane_align u_align (
    .wdata    (req_wdata),
    .offs     (req_addr[1:0]),
    .len      (req_len),
    .rword    (mem[idx]),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = CNT_INIT;
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Response is computed at acceptance and held untouched until the next acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= (err || req_wen) ? 32'h0 : ld_data;
      rsp_err   <= err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_wen && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_len = '0;
  logic        req_wen = 1'b0;
  logic        rsp_ready = 1'b0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        v_ready, v_valid, v_err;
  logic [31:0] v_rdata;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_responder u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid & ~sel),
    .req_ready (a_req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .req_wen   (req_wen),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1), .BASE(32'h100)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid & sel),
    .req_ready (b_req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .req_wen   (req_wen),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  assign v_ready = sel ? b_req_ready : a_req_ready;
  assign v_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign v_err   = sel ? b_rsp_err   : a_rsp_err;
  assign v_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] len, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int guard;
    int lat;
    guard = 0;
    lat = 1;
    req_addr = addr;
    req_wdata = wdata;
    req_len = len;
    req_wen = wen;
    req_valid = 1'b1;
    while (!v_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!v_ready) begin
      check({tag, " ready_timeout"}, 32'(v_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!v_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    if (!v_valid) return;
    check({tag, " rdata"}, v_rdata, exp_rdata);
    check({tag, " err"}, 32'(v_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold_vld_rdy"}, {30'h0, v_valid, v_ready}, 32'h2);
      check({tag, " hold_rdata"}, v_rdata, exp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (hold > 0) check({tag, " back_idle"}, {30'h0, v_valid, v_ready}, 32'h1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(a_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
    reset = 1'b0;
    #10;

    xact("st_w",        1'b1, 32'h10,  32'hDEADBEEF, 3'd4, 0, 32'h0,        1'b0, 2);
    xact("ld_w",        1'b0, 32'h10,  32'h0,        3'd4, 0, 32'hDEADBEEF, 1'b0, 2);
    xact("st_b",        1'b1, 32'h11,  32'hAAAAAA55, 3'd1, 0, 32'h0,        1'b0, 2);
    xact("ld_w2",       1'b0, 32'h10,  32'h0,        3'd4, 0, 32'hDEAD55EF, 1'b0, 2);
    xact("ld_h",        1'b0, 32'h12,  32'h0,        3'd2, 0, 32'h0000DEAD, 1'b0, 2);
    xact("ld_b",        1'b0, 32'h13,  32'h0,        3'd1, 0, 32'h000000DE, 1'b0, 2);
    xact("ld_mis_w",    1'b0, 32'h13,  32'h0,        3'd4, 0, 32'h0,        1'b1, 2);
    xact("ld_mis_h",    1'b0, 32'h11,  32'h0,        3'd2, 0, 32'h0,        1'b1, 2);
    xact("ld_len3",     1'b0, 32'h10,  32'h0,        3'd3, 0, 32'h0,        1'b1, 2);
    xact("st_mis",      1'b1, 32'h12,  32'h11223344, 3'd4, 0, 32'h0,        1'b1, 2);
    xact("ld_unchgd",   1'b0, 32'h10,  32'h0,        3'd4, 0, 32'hDEAD55EF, 1'b0, 2);
    xact("hold",        1'b0, 32'h10,  32'h0,        3'd4, 5, 32'hDEAD55EF, 1'b0, 2);
    xact("after_hold",  1'b0, 32'h12,  32'h0,        3'd2, 0, 32'h0000DEAD, 1'b0, 2);
    xact("ld_oor",      1'b0, 32'h1000, 32'h0,       3'd4, 0, 32'h0,        1'b1, 2);
    xact("st_last",     1'b1, 32'hFFC, 32'h0BADF00D, 3'd4, 0, 32'h0,        1'b0, 2);
    xact("ld_last",     1'b0, 32'hFFC, 32'h0,        3'd4, 0, 32'h0BADF00D, 1'b0, 2);

    // reset while the store to 0x20 is waiting for its response
    req_addr = 32'h20;
    req_wdata = 32'h12345678;
    req_len = 3'd4;
    req_wen = 1'b1;
    req_valid = 1'b1;
    check("mrst_pre_ready", 32'(a_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mrst_in_wait", {30'h0, a_rsp_valid, a_req_ready}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("mrst_req_ready", 32'(a_req_ready), 32'd0);
    check("mrst_rsp_rdata", a_rsp_rdata, 32'h0);
    check("mrst_rsp_err", 32'(a_rsp_err), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mrst_no_rsp", {30'h0, a_rsp_valid, a_req_ready}, 32'h1);
    end
    xact("ld_committed", 1'b0, 32'h20, 32'h0, 3'd4, 0, 32'h12345678, 1'b0, 2);

    sel = 1'b1;
    xact("b_oor_hi",    1'b0, 32'h200, 32'h0,        3'd4, 0, 32'h0,        1'b1, 1);
    xact("b_oor_lo",    1'b0, 32'hFC,  32'h0,        3'd4, 0, 32'h0,        1'b1, 1);
    xact("b_st",        1'b1, 32'h100, 32'hCAFEF00D, 3'd4, 0, 32'h0,        1'b0, 1);
    xact("b_ld_h",      1'b0, 32'h102, 32'h0,        3'd2, 0, 32'h0000CAFE, 1'b0, 1);
    xact("b_st_last",   1'b1, 32'h1FC, 32'h89ABCDEF, 3'd4, 0, 32'h0,        1'b0, 1);
    xact("b_ld_last",   1'b0, 32'h1FD, 32'h0,        3'd1, 0, 32'h000000CD, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
